max_seq_ctrl: RTL and testbench
===============================

# max_seq_ctrl

Sequencing controller for the team's max-reduction datapath. It accepts a job of `len` unsigned operands over a valid/ready stream and feeds each one through a single shared comparator. It tracks the running maximum and the index where that maximum first occurs, then presents the result on a held output handshake. It sits between an operand source and a downstream consumer, and holds the max unit (exact or BMF-approximated) as its compare stage.

## Interface
Parameters:
- `WIDTH`, 5: operand and result width in bits, unsigned.
- `LEN_W`, 8: width of the job length and index fields.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  operand count for the job; captured with `start`.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  operand accept; high only in RUN.
- `in_data`  in  WIDTH  operand value.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  consumer accept.
- `out_max`  out  WIDTH  maximum of the job.
- `out_idx`  out  LEN_W  index (0-based) of the first occurrence of `out_max`.
- `out_empty`  out  1  the job had `len == 0`; valid with `out_valid`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
FSM states are IDLE, RUN and DONE.
- IDLE:
  - `start=1`, `len!=0`: capture `len`, clear `count`, go to RUN.
  - `start=1`, `len==0`: set `out_max=0`, `out_idx=0`, `out_empty=1`, go to DONE.
- RUN: one beat is accepted on each cycle with `in_valid & in_ready`.
  - On the beat with `count==0`, or when `in_data > max` (strict compare from the comparator), load `max=in_data` and `idx=count`.
  - Ties keep the earlier index.
  - `count` increments on every accepted beat.
  - The beat with `count==len-1` moves the FSM to DONE.
- DONE: outputs are held stable until `out_valid & out_ready`, then the FSM returns to IDLE.
- Other rules:
  - `start` outside IDLE is ignored, with no queuing.
  - `len` is unsigned. The maximum job is 2^LEN_W−1 operands, so `count` never wraps.
  - `out_empty=0` for any non-empty job.
- Reset, effective immediately even mid-job: state=IDLE, `count=0`, `max=0`, `idx=0`, `out_empty=0`. All outputs are 0 (`in_ready`, `out_valid`, `busy`, `out_max`, `out_idx`, `out_empty`). Any partial job is discarded.

## Timing
- `start` accepted at edge N gives `busy=1` and, for non-empty jobs, `in_ready=1` from cycle N+1.
- Throughput is one operand per cycle while `in_valid` stays high. The bubble cycles follow `in_valid`.
- Latency: last beat accepted at edge M gives `out_valid=1` in cycle M+1, with the final `out_max`/`out_idx` already registered.
- `in_ready` drops in the same cycle `out_valid` rises. No beat is accepted beyond `len`.
- An empty job gives `out_valid=1` in the cycle after `start`.
- Output handshake at edge K gives IDLE in cycle K+1. The earliest next `start` is sampled at edge K+1, so there is one mandatory IDLE cycle between jobs.
- `start` coinciding with the output handshake is ignored.
- Every output is a register or a pure decode of the state register. There are no combinational paths from inputs to outputs.

## Structure
- Package `max_seq_pkg`:
  - state enum `{IDLE, RUN, DONE}`.
  - default `WIDTH`/`LEN_W` constants.
- Sub-module `max_cmp`:
  - combinational, `gt = a > b` over `WIDTH` bits.
  - instantiated once.
  - this is where an approximate max netlist is swapped in. The controller treats its output as authoritative.
- The controller holds the FSM, `count`, `len` latch, and the `max`/`idx` registers.

## Test plan
- Reset mid-job: assert `rst_n=0` during RUN → all outputs 0 immediately. A new job after release runs clean.
- `len=4`, data 3,17,9,17 with continuous valid → `out_valid` one cycle after the 4th beat, `out_max=17`, `out_idx=1`, `out_empty=0`.
- `len=3`, data 31,0,5, with `in_valid` gaps and `out_ready` held low 5 cycles → `out_max=31`, `out_idx=0`. Outputs stable throughout the stall. Exactly 3 beats accepted.
- `len=0` → `out_valid` the next cycle, `out_empty=1`, `out_max=0`, `out_idx=0`.
- `start` pulsed during RUN and on the output-handshake cycle → both ignored. `start` one cycle later is accepted.
- `len=255`, ascending data 0..254 (operand width raised to `WIDTH=8` for this test) → `out_max=254`, `out_idx=254`. `count` does not wrap.

Source files
------------

// File: rtl/max_seq_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | max_seq_pkg : shared types and defaults for the max sequencer     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package max_seq_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/max_seq_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | max_seq_ctrl_if : job, operand-stream and result handshakes        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface max_seq_ctrl_if #(
  parameter int WIDTH = max_seq_pkg::DEF_WIDTH,
  parameter int LEN_W = max_seq_pkg::DEF_LEN_W
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [LEN_W-1:0] out_idx;
  logic             out_empty;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_empty, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_empty, busy
  );
endinterface
`default_nettype wire

// File: rtl/max_seq_ctrl_cmp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | max_cmp : strict unsigned greater-than; approx netlists drop in   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module max_cmp #(
  parameter int WIDTH = max_seq_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);
  assign gt = (a > b);
endmodule
`default_nettype wire

// File: rtl/max_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | max_seq_ctrl : feeds a job of operands through one comparator and |
// | returns the running max and its first index. Rev 1.0              |
// +------------------------------------------------------------------+
module max_seq_ctrl
  import max_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  max_seq_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_idx;
  logic [WIDTH-1:0] r_max;
  logic             r_empty;
  logic             w_gt;
  logic             w_beat;
  logic             w_last;

  max_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a  (bus.in_data),
    .b  (r_max),
    .gt (w_gt)
  );

  assign w_beat = (r_state == RUN) & bus.in_valid;
  assign w_last = (r_count == r_len - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = (bus.len != '0) ? RUN : DONE;
      RUN:  if (w_beat && w_last) w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_max   <= '0;
      r_empty <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      if (bus.len != '0) begin
        r_len   <= bus.len;
        r_count <= '0;
        r_empty <= 1'b0;
      end else begin
        r_max   <= '0;
        r_idx   <= '0;
        r_empty <= 1'b1;
      end
    end else if (w_beat) begin
      r_count <= r_count + 1'b1;
      // first beat seeds the max; strict compare keeps the earliest index on ties
      if (r_count == '0 || w_gt) begin
        r_max <= bus.in_data;
        r_idx <= r_count;
      end
    end
  end

  assign bus.in_ready  = (r_state == RUN);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_max   = r_max;
  assign bus.out_idx   = r_idx;
  assign bus.out_empty = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_max_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_max_seq_ctrl : scoreboard bench for the max sequencer          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_max_seq_ctrl;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] idx;
    logic       empty;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  logic [7:0] stim [0:255];

  max_seq_ctrl_if #(.WIDTH(5), .LEN_W(8)) ia ();
  max_seq_ctrl_if #(.WIDTH(8), .LEN_W(8)) ib ();

  max_seq_ctrl #(.WIDTH(5), .LEN_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  max_seq_ctrl #(.WIDTH(8), .LEN_W(8)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int n);
    exp_t e;
    e.mx = 8'd0; e.idx = 8'd0; e.empty = (n == 0);
    for (int i = 0; i < n; i++)
      if (i == 0 || stim[i] > e.mx) begin
        e.mx  = stim[i];
        e.idx = 8'(i);
      end
    return e;
  endfunction

  task automatic pop_cmp(input logic [7:0] mx, input logic [7:0] idx, input logic empty);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("out_max", mx, e.mx);
      chk("out_idx", idx, e.idx);
      chk("out_empty", empty, e.empty);
    end
  endtask

  // One job on the WIDTH=5 instance; called at #1 after a rising edge with the DUT idle.
  task automatic run_job(input int n, input bit gaps, input int stall,
                         input bit start_in_run, input bit start_on_hs);
    exp_t e;
    int   acc, cyc;
    bit   just_last;
    e = model(n);
    sb.push_back(e);
    ia.start = 1'b1; ia.len = 8'(n);
    @(posedge clk); #1;
    ia.start = 1'b0;
    chk("busy_after_start", ia.busy, 1);
    chk("in_ready_after_start", ia.in_ready, (n != 0));
    if (n == 0) chk("empty_latency", ia.out_valid, 1);
    acc = 0; cyc = 0; just_last = 1'b0;
    while (!ia.out_valid && cyc < 2000) begin
      ia.start    = (start_in_run && cyc == 1);
      ia.len      = 8'd0;
      ia.in_valid = !(gaps && $urandom_range(0, 2) == 0);
      ia.in_data  = (acc < n) ? stim[acc][4:0] : 5'd31;
      just_last   = 1'b0;
      if (ia.in_valid && ia.in_ready) begin
        acc++;
        just_last = (acc == n);
      end
      @(posedge clk); #1;
      cyc++;
    end
    ia.start = 1'b0; ia.in_valid = 1'b0;
    chk("out_valid_timeout", (cyc < 2000), 1);
    if (n != 0) chk("out_valid_latency", just_last, 1);
    chk("in_ready_in_done", ia.in_ready, 0);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", ia.out_valid, 1);
      chk("stall_max", ia.out_max, e.mx);
      chk("stall_idx", ia.out_idx, e.idx);
      @(posedge clk); #1;
    end
    ia.out_ready = 1'b1;
    ia.start     = start_on_hs;
    ia.len       = 8'd3;
    pop_cmp({3'd0, ia.out_max}, ia.out_idx, ia.out_empty);
    @(posedge clk); #1;
    ia.out_ready = 1'b0; ia.start = 1'b0;
    chk("beats_accepted", acc, n);
    chk("valid_after_hs", ia.out_valid, 0);
    chk("busy_after_hs", ia.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, cyc;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    ia.start = 0; ia.len = 0; ia.in_valid = 0; ia.in_data = 0; ia.out_ready = 0;
    ib.start = 0; ib.len = 0; ib.in_valid = 0; ib.in_data = 0; ib.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ia.busy, 0);
    chk("rst_in_ready", ia.in_ready, 0);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_out_empty", ia.out_empty, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-job: partial job abandoned, no scoreboard entry.
    ia.start = 1'b1; ia.len = 8'd4;
    @(posedge clk); #1;
    ia.start = 1'b0; ia.in_valid = 1'b1; ia.in_data = 5'd3;
    @(posedge clk); #1;
    ia.in_data = 5'd17;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", ia.busy, 0);
    chk("midrst_in_ready", ia.in_ready, 0);
    chk("midrst_out_valid", ia.out_valid, 0);
    chk("midrst_out_max", ia.out_max, 0);
    chk("midrst_out_idx", ia.out_idx, 0);
    chk("midrst_out_empty", ia.out_empty, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    stim[0] = 8'd3; stim[1] = 8'd17; stim[2] = 8'd9; stim[3] = 8'd17;
    run_job(4, 1'b0, 0, 1'b0, 1'b0);

    stim[0] = 8'd31; stim[1] = 8'd0; stim[2] = 8'd5;
    run_job(3, 1'b1, 5, 1'b0, 1'b0);

    run_job(0, 1'b0, 1, 1'b0, 1'b0);

    stim[0] = 8'd4; stim[1] = 8'd4; stim[2] = 8'd2; stim[3] = 8'd7; stim[4] = 8'd7;
    run_job(5, 1'b0, 2, 1'b1, 1'b1);

    stim[0] = 8'd9; stim[1] = 8'd1;
    run_job(2, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) stim[i] = 8'($urandom_range(0, 31));
    run_job(12, 1'b1, 1, 1'b0, 1'b0);

    // Full-length job on the 8-bit instance.
    for (int i = 0; i < 255; i++) stim[i] = 8'(i);
    sb.push_back(model(255));
    ib.start = 1'b1; ib.len = 8'd255;
    @(posedge clk); #1;
    ib.start = 1'b0;
    acc = 0; cyc = 0;
    while (!ib.out_valid && cyc < 2000) begin
      ib.in_valid = 1'b1;
      ib.in_data  = (acc < 255) ? stim[acc] : 8'hFF;
      if (ib.in_valid && ib.in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    ib.in_valid = 1'b0;
    chk("w8_timeout", (cyc < 2000), 1);
    chk("w8_beats", acc, 255);
    chk("w8_cycles", cyc, 255);
    ib.out_ready = 1'b1;
    pop_cmp(ib.out_max, ib.out_idx, ib.out_empty);
    @(posedge clk); #1;
    ib.out_ready = 1'b0;
    chk("w8_busy_after_hs", ib.busy, 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
